// File: rtl/sb_init_tx_serializer.sv
// SBINIT sideband transmit serializer: clock-pattern bursts and 64-bit message packets, LSB-first.
// Define SB_TX_PARITY_EN to fill packet bit 63 with the XOR of bits 62:0.
module sb_init_tx_serializer #(
    parameter int SB_MSG_WIDTH = 4,
    parameter int PATTERN_UI   = 64,
    parameter int GAP_UI       = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start_pattern_req,
    input  logic                    i_tx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
    output logic                    o_start_pattern_done,
    output logic                    o_SB_Busy,
    output logic                    o_falling_edge_busy,
    output logic                    o_sb_data,
    output logic                    o_sb_clk_en,
    output logic                    o_unknown_msg,
    output logic                    o_msg_drop
);

    localparam int PKT_W  = 64;
    localparam int MAX_A  = (PATTERN_UI > PKT_W) ? PATTERN_UI : PKT_W;
    localparam int MAX_UI = (GAP_UI > MAX_A) ? GAP_UI : MAX_A;
    localparam int CNT_W  = $clog2(MAX_UI);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PATTERN = 3'd1;
    localparam logic [2:0] ST_PAT_GAP = 3'd2;
    localparam logic [2:0] ST_MSG     = 3'd3;
    localparam logic [2:0] ST_MSG_GAP = 3'd4;

    logic [2:0]              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [PKT_W-1:0]        packet, packet_n;
    logic                    pend_valid, pend_valid_n;
    logic [SB_MSG_WIDTH-1:0] pend_code, pend_code_n;
    logic                    pattern_pend, pattern_pend_n;
    logic                    req_q, armed;
    logic                    done_n, fe_n, unk_n, drop_n, msg_taken;
    logic                    start, new_mapped;

    function automatic logic is_mapped(input logic [SB_MSG_WIDTH-1:0] code);
        return (code == SB_MSG_WIDTH'(1)) || (code == SB_MSG_WIDTH'(2)) ||
               (code == SB_MSG_WIDTH'(3));
    endfunction

    function automatic logic [PKT_W-1:0] build_packet(input logic [SB_MSG_WIDTH-1:0] code);
        logic [7:0]       msgcode;
        logic [7:0]       subcode;
        logic [PKT_W-1:0] pkt;
        case (code)
            SB_MSG_WIDTH'(1): begin msgcode = 8'h91; subcode = 8'h00; end
            SB_MSG_WIDTH'(2): begin msgcode = 8'h95; subcode = 8'h01; end
            SB_MSG_WIDTH'(3): begin msgcode = 8'h9A; subcode = 8'h01; end
            default:          begin msgcode = 8'h00; subcode = 8'h00; end
        endcase
        pkt        = '0;
        pkt[4:0]   = 5'b10010;
        pkt[21:14] = msgcode;
        pkt[39:32] = subcode;
`ifdef SB_TX_PARITY_EN
        pkt[63]    = ^pkt[62:0];
`else
        pkt[63]    = 1'b0;
`endif
        return pkt;
    endfunction

    // armed stays low after reset until the request is seen low, so a request
    // held high across reset does not count as a fresh edge.
    assign start      = i_start_pattern_req & ~req_q & armed;
    assign new_mapped = i_tx_msg_valid & is_mapped(i_encoded_SB_msg);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_n        = state;
        cnt_n          = cnt;
        packet_n       = packet;
        pend_valid_n   = pend_valid;
        pend_code_n    = pend_code;
        pattern_pend_n = pattern_pend;
        done_n         = 1'b0;
        fe_n           = 1'b0;
        drop_n         = 1'b0;
        msg_taken      = 1'b0;
        unk_n          = i_tx_msg_valid & (i_encoded_SB_msg != '0) & ~is_mapped(i_encoded_SB_msg);

        case (state)
            ST_IDLE: begin
                if (start || pattern_pend) begin
                    state_n        = ST_PATTERN;
                    cnt_n          = '0;
                    pattern_pend_n = 1'b0;
                end else if (pend_valid) begin
                    state_n      = ST_MSG;
                    cnt_n        = '0;
                    packet_n     = build_packet(pend_code);
                    pend_valid_n = 1'b0;
                end else if (new_mapped) begin
                    state_n   = ST_MSG;
                    cnt_n     = '0;
                    packet_n  = build_packet(i_encoded_SB_msg);
                    msg_taken = 1'b1;
                end
            end
            ST_PATTERN: begin
                if (cnt == CNT_W'(PATTERN_UI - 1)) begin
                    state_n = ST_PAT_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_PAT_GAP: begin
                if (cnt == CNT_W'(GAP_UI - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    fe_n    = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_MSG: begin
                if (cnt == CNT_W'(PKT_W - 1)) begin
                    state_n = ST_MSG_GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_MSG_GAP: begin
                if (cnt == CNT_W'(GAP_UI - 1)) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    fe_n    = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase

        if (start && (state != ST_IDLE))
            pattern_pend_n = 1'b1;

        // A slot emptied by this cycle's job choice may be refilled at once.
        if (new_mapped && !msg_taken) begin
            if (!pend_valid_n) begin
                pend_valid_n = 1'b1;
                pend_code_n  = i_encoded_SB_msg;
            end else begin
                drop_n = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state                <= ST_IDLE;
            cnt                  <= '0;
            packet               <= '0;
            pend_valid           <= 1'b0;
            pend_code            <= '0;
            pattern_pend         <= 1'b0;
            req_q                <= 1'b0;
            armed                <= 1'b0;
            o_SB_Busy            <= 1'b0;
            o_start_pattern_done <= 1'b0;
            o_falling_edge_busy  <= 1'b0;
            o_unknown_msg        <= 1'b0;
            o_msg_drop           <= 1'b0;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            packet               <= packet_n;
            pend_valid           <= pend_valid_n;
            pend_code            <= pend_code_n;
            pattern_pend         <= pattern_pend_n;
            req_q                <= i_start_pattern_req;
            armed                <= armed | ~i_start_pattern_req;
            o_SB_Busy            <= (state_n != ST_IDLE);
            o_start_pattern_done <= done_n;
            o_falling_edge_busy  <= fe_n;
            o_unknown_msg        <= unk_n;
            o_msg_drop           <= drop_n;
        end
    end

    assign o_sb_data   = ((state == ST_PATTERN) & ~cnt[0]) |
                         ((state == ST_MSG) & packet[cnt[5:0]]);
    assign o_sb_clk_en = (state == ST_PATTERN) | (state == ST_MSG);

endmodule

// File: tb/tb_sb_init_tx_serializer.sv
// Self-checking bench for sb_init_tx_serializer: vector table, directed corner sequences,
// and randomized traffic compared cycle by cycle against a job-queue reference model.
module tb_sb_init_tx_serializer;

    localparam int SB_MSG_WIDTH = 4;
    localparam int PATTERN_UI   = 64;
    localparam int GAP_UI       = 32;
`ifdef SB_TX_PARITY_EN
    localparam logic PAR = 1'b1;
`else
    localparam logic PAR = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       req   = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] code  = 4'd0;
    logic       o_start_pattern_done, o_SB_Busy, o_falling_edge_busy;
    logic       o_sb_data, o_sb_clk_en, o_unknown_msg, o_msg_drop;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    sb_init_tx_serializer #(
        .SB_MSG_WIDTH(SB_MSG_WIDTH),
        .PATTERN_UI  (PATTERN_UI),
        .GAP_UI      (GAP_UI)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_start_pattern_req (req),
        .i_tx_msg_valid      (valid),
        .i_encoded_SB_msg    (code),
        .o_start_pattern_done(o_start_pattern_done),
        .o_SB_Busy           (o_SB_Busy),
        .o_falling_edge_busy (o_falling_edge_busy),
        .o_sb_data           (o_sb_data),
        .o_sb_clk_en         (o_sb_clk_en),
        .o_unknown_msg       (o_unknown_msg),
        .o_msg_drop          (o_msg_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference model: each job is expanded into a queue of per-UI outputs.
    typedef struct packed {
        logic d;
        logic ce;
    } ui_t;

    ui_t  wave[$];
    int   pend_q[$];
    bit   m_req_prev, m_armed, m_pat_pend, m_busy, m_last_pat;
    logic m_d, m_ce, m_done, m_fe, m_unk, m_drop;

    function automatic bit ref_mapped(input int c);
        return (c >= 1) && (c <= 3);
    endfunction

    function automatic logic [63:0] ref_packet(input int c);
        logic [63:0] mc, sc, p;
        mc = 64'h0;
        sc = 64'h0;
        case (c)
            1: begin mc = 64'h91; sc = 64'h00; end
            2: begin mc = 64'h95; sc = 64'h01; end
            3: begin mc = 64'h9A; sc = 64'h01; end
            default: ;
        endcase
        p = 64'h12 | (mc << 14) | (sc << 32);
        if (PAR) p[63] = ^p[62:0];
        return p;
    endfunction

    task automatic model_reset();
        wave.delete();
        pend_q.delete();
        m_req_prev = 0; m_armed = 0; m_pat_pend = 0; m_busy = 0; m_last_pat = 0;
        m_d = 0; m_ce = 0; m_done = 0; m_fe = 0; m_unk = 0; m_drop = 0;
    endtask

    task automatic load_msg(input int c);
        logic [63:0] p;
        p = ref_packet(c);
        for (int i = 0; i < 64; i++) wave.push_back('{d: p[i], ce: 1'b1});
        for (int i = 0; i < GAP_UI; i++) wave.push_back('{d: 1'b0, ce: 1'b0});
        m_last_pat = 0;
    endtask

    task automatic model_edge(input bit r, input bit v, input int c);
        bit  st, taken;
        ui_t u;
        st = r && !m_req_prev && m_armed;
        if (!r) m_armed = 1;
        m_req_prev = r;
        m_unk  = v && (c != 0) && !ref_mapped(c);
        m_drop = 0; m_done = 0; m_fe = 0; taken = 0;
        if (!m_busy) begin
            if (st || m_pat_pend) begin
                m_pat_pend = 0;
                m_last_pat = 1;
                for (int i = 0; i < PATTERN_UI; i++) wave.push_back('{d: (i % 2 == 0), ce: 1'b1});
                for (int i = 0; i < GAP_UI; i++) wave.push_back('{d: 1'b0, ce: 1'b0});
            end else if (pend_q.size() > 0) begin
                load_msg(pend_q.pop_front());
            end else if (v && ref_mapped(c)) begin
                load_msg(c);
                taken = 1;
            end
        end else if (st) begin
            m_pat_pend = 1;
        end
        if (v && ref_mapped(c) && !taken) begin
            if (pend_q.size() == 0) pend_q.push_back(c);
            else m_drop = 1;
        end
        if (wave.size() > 0) begin
            u = wave.pop_front();
            m_d = u.d; m_ce = u.ce; m_busy = 1;
        end else begin
            if (m_busy) begin
                m_fe = 1;
                m_done = m_last_pat;
            end
            m_busy = 0; m_d = 0; m_ce = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [3:0] c);
        req = r; valid = v; code = c;
        @(posedge i_clk);
        #1;
        cyc++;
        model_edge(r, v, int'(c));
        check("outputs", {o_SB_Busy, o_falling_edge_busy, o_start_pattern_done, o_sb_data,
                          o_sb_clk_en, o_unknown_msg, o_msg_drop},
              {m_busy, m_fe, m_done, m_d, m_ce, m_unk, m_drop});
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(r, 1'b0, 4'd0);
    endtask

    task automatic apply_reset();
        valid = 1'b0;
        i_rst = 1'b1;
        #1;
        check("reset outputs", {o_SB_Busy, o_falling_edge_busy, o_start_pattern_done, o_sb_data,
                                o_sb_clk_en, o_unknown_msg, o_msg_drop}, 64'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        cyc = 0;
    endtask

    // Runs n cycles with req held, counting busy falls and capturing the packet
    // that starts the cycle after the pattern-done pulse.
    task automatic run_collect(input int n, input bit r, output int fe_cnt,
                               output bit saw_done, output logic [63:0] bits);
        int done_cyc;
        fe_cnt = 0; saw_done = 0; bits = '0; done_cyc = -1;
        for (int i = 0; i < n; i++) begin
            step(r, 1'b0, 4'd0);
            if (o_falling_edge_busy) fe_cnt++;
            if (o_start_pattern_done) begin saw_done = 1; done_cyc = cyc; end
            if (done_cyc >= 0 && cyc > done_cyc && cyc <= done_cyc + 64)
                bits[cyc - done_cyc - 1] = o_sb_data;
        end
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [63:0] pkt;
        logic        busy;
        logic        unk;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          fe_cnt, busy_cnt, done_cnt;
        bit          saw_done;
        logic [63:0] bits;
        logic        r;

        tbl[0] = '{4'd1, 64'h0000_0000_0024_4012 | {PAR, 63'd0}, 1'b1, 1'b0};
        tbl[1] = '{4'd2, 64'h0000_0001_0025_4012 | {PAR, 63'd0}, 1'b1, 1'b0};
        tbl[2] = '{4'd3, 64'h0000_0001_0026_8012 | {PAR, 63'd0}, 1'b1, 1'b0};
        tbl[3] = '{4'd0, 64'h0, 1'b0, 1'b0};
        tbl[4] = '{4'd7, 64'h0, 1'b0, 1'b1};
        tbl[5] = '{4'd15, 64'h0, 1'b0, 1'b1};

        // Pattern burst from a request raised at cycle 10 and held.
        apply_reset();
        idle(10, 1'b0);
        while (cyc < 107) begin
            step(1'b1, 1'b0, 4'd0);
            if (cyc == 11) check("t1 first UI", {o_sb_data, o_sb_clk_en}, 2'b11);
            if (cyc == 74) check("t1 last UI", {o_sb_data, o_sb_clk_en}, 2'b01);
            if (cyc == 75) check("t1 gap start", {o_sb_data, o_sb_clk_en, o_SB_Busy}, 3'b001);
            if (cyc == 106) check("t1 gap end", {o_start_pattern_done, o_SB_Busy}, 2'b01);
        end
        check("t1 done", {o_start_pattern_done, o_falling_edge_busy, o_SB_Busy}, 3'b110);
        busy_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1, 1'b0, 4'd0);
            if (o_SB_Busy) busy_cnt++;
        end
        check("t1 no rerun", busy_cnt, 0);

        // Table of single messages sent from IDLE.
        idle(5, 1'b0);
        foreach (tbl[k]) begin
            step(1'b0, 1'b1, tbl[k].code);
            check("tbl unknown", o_unknown_msg, tbl[k].unk);
            check("tbl busy", o_SB_Busy, tbl[k].busy);
            bits = '0;
            bits[0] = o_sb_data;
            for (int i = 1; i < 64; i++) begin
                step(1'b0, 1'b0, 4'd0);
                bits[i] = o_sb_data;
            end
            check("tbl packet", bits, tbl[k].pkt);
            idle(GAP_UI + 2, 1'b0);
        end

        // Strobes during a pattern: first is held pending, second is dropped.
        step(1'b1, 1'b0, 4'd0);
        idle(5, 1'b1);
        step(1'b1, 1'b1, 4'd1);
        idle(3, 1'b1);
        step(1'b1, 1'b1, 4'd3);
        check("t3 drop", o_msg_drop, 1'b1);
        run_collect(200, 1'b1, fe_cnt, saw_done, bits);
        check("t3 done seen", saw_done, 1'b1);
        check("t3 fe pulses", fe_cnt, 2);
        check("t3 packet", bits, tbl[0].pkt);

        // Same-cycle start edge and message: pattern first, packet after one idle cycle.
        idle(3, 1'b0);
        step(1'b1, 1'b1, 4'd3);
        check("t4 pattern first", {o_sb_clk_en, o_sb_data}, 2'b11);
        run_collect(220, 1'b1, fe_cnt, saw_done, bits);
        check("t4 done seen", saw_done, 1'b1);
        check("t4 fe pulses", fe_cnt, 2);
        check("t4 packet", bits, tbl[2].pkt);

        // Unmapped code from IDLE.
        step(1'b1, 1'b1, 4'd7);
        check("t5 unknown", {o_unknown_msg, o_SB_Busy, o_sb_data}, 3'b100);
        step(1'b1, 1'b0, 4'd0);
        check("t5 one-cycle", {o_unknown_msg, o_SB_Busy}, 2'b00);

        // Reset at pattern UI 20 with the request held high through and after it.
        idle(3, 1'b0);
        step(1'b1, 1'b0, 4'd0);
        idle(20, 1'b1);
        check("t6 at UI20", {o_sb_data, o_sb_clk_en}, 2'b11);
        apply_reset();
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 150; i++) begin
            step(1'b1, 1'b0, 4'd0);
            if (o_SB_Busy) busy_cnt++;
            if (o_start_pattern_done || o_falling_edge_busy) done_cnt++;
        end
        check("t6 no burst", busy_cnt, 0);
        check("t6 no done", done_cnt, 0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 4'd0);
        check("t6 rearmed", {o_SB_Busy, o_sb_clk_en, o_sb_data}, 3'b111);
        idle(PATTERN_UI + GAP_UI + 2, 1'b1);

        // Randomized traffic against the model, with one reset midway.
        r = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) apply_reset();
            if ($urandom_range(0, 99) < 3) r = ~r;
            step(r, ($urandom_range(0, 99) < 8), 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sb_init_tx_serializer.md
Name: sb_init_tx_serializer

Overview:
- Sideband transmit responder serving the SBINIT state machine of the LTSM.
- Accepts a start-pattern request and emits the SBINIT clock pattern (toggle burst, then low gap), then reports done.
- Accepts 4-bit encoded SBINIT messages with valid, expands each to a 64-bit sideband message packet and serializes it LSB-first.
- Drives the busy and busy-falling-edge status that the SBINIT logic uses for flow control.

Parameters:
SB_MSG_WIDTH, 4, width of the encoded message code
PATTERN_UI, 64, UI count of the alternating clock-pattern burst (even, ≥2)
GAP_UI, 32, UI count of the low gap after a pattern burst or packet (≥1)

Ports:
i_clk  input  1  sideband serializer clock, 1 UI per cycle
i_rst  input  1  asynchronous active-high reset
i_start_pattern_req  input  1  level request; its rising edge starts one pattern burst
i_tx_msg_valid  input  1  one-cycle strobe qualifying i_encoded_SB_msg
i_encoded_SB_msg  input  SB_MSG_WIDTH  encoded SBINIT message code
o_start_pattern_done  output  1  one-cycle pulse at pattern burst + gap completion
o_SB_Busy  output  1  high while any burst/packet/gap is in progress
o_falling_edge_busy  output  1  one-cycle pulse on each 1→0 transition of o_SB_Busy
o_sb_data  output  1  serial sideband data
o_sb_clk_en  output  1  forwarded-clock enable: high only on pattern/packet UIs, low in gaps/idle
o_unknown_msg  output  1  one-cycle pulse: unmapped code accepted and discarded
o_msg_drop  output  1  one-cycle pulse: strobe lost because pending slot full

Behaviour:
- Reset (async, immediate): state IDLE, counters 0, pending slot empty, req edge register 0; every output 0.
- States: IDLE, PATTERN, PAT_GAP, MSG, MSG_GAP. o_SB_Busy = registered (state != IDLE).
- Request edge: req_q registers i_start_pattern_req every cycle; start = req & ~req_q.
- IDLE priority in a cycle: start > pending message > new i_tx_msg_valid. Chosen job's state entered next cycle.
- A start edge seen outside IDLE is latched (pattern_pend) and served at the next IDLE with top priority; a second edge while latched is ignored.
- PATTERN: UI counter 0..PATTERN_UI-1; o_sb_data = 1 on even index, 0 on odd; o_sb_clk_en = 1. After the last UI → PAT_GAP.
- PAT_GAP: GAP_UI cycles with o_sb_data = 0 and o_sb_clk_en = 0. Then → IDLE. o_start_pattern_done pulses in the first IDLE cycle.
- Latency: a start edge at cycle t gives the first pattern UI at t+1 and the done pulse at t+1+PATTERN_UI+GAP_UI.
- Message code map (msgcode, subcode):
  - 1 → SBINIT out of reset (0x91, 0x00)
  - 2 → SBINIT done req (0x95, 0x01)
  - 3 → SBINIT done resp (0x9A, 0x01)
  - 0 → ignored silently
  - others → o_unknown_msg pulse, no packet sent
- Packet, 64 bits:
  - [4:0] = 5'b10010
  - [21:14] = msgcode
  - [39:32] = subcode
  - [63] = parity (see Optional Feature)
  - all other bits 0
- Packet is latched when its job is chosen.
- MSG: 64 UIs, o_sb_data = packet[idx] with idx 0..63; o_sb_clk_en = 1. Then MSG_GAP: GAP_UI low cycles, then → IDLE.
- i_tx_msg_valid while busy (or in IDLE when losing priority): the code is stored in the 1-deep pending slot if empty. If the slot is already full, the new strobe is discarded and o_msg_drop pulses. Codes 0 and unmapped are filtered before storage.
- Back-to-back jobs: IDLE is always held ≥1 cycle between jobs. Busy therefore falls for ≥1 cycle and o_falling_edge_busy pulses once per completed job.
- o_falling_edge_busy = busy_q & ~o_SB_Busy, registered; it pulses in the same cycle as o_start_pattern_done for pattern jobs.
- Reset mid-job: the job is aborted immediately and all outputs return to 0; no done pulse or falling-edge pulse is generated.

Optional Feature:
- Macro SB_TX_PARITY_EN.
- Defined: packet[63] = XOR of packet[62:0], computed at latch time.
- Undefined: packet[63] = 0; no parity logic is synthesized.
- Resulting packet[63] for the mapped messages:
  - Code 1 (0x91/0x00) has odd weight over [62:0] (opcode 2 + msgcode 3 = 5 ones), so packet[63] = 1 when enabled.
  - Code 2 (0x95/0x01): 2 + 4 + 1 = 7 ones → packet[63] = 1.
  - Code 3 (0x9A/0x01): 2 + 4 + 1 = 7 ones → packet[63] = 1.

Test Plan:
- Reset, raise i_start_pattern_req at cycle 10 and hold → o_sb_data toggles 1,0 for cycles 11–74 with clk_en 1; low cycles 75–106 with clk_en 0; o_start_pattern_done, o_falling_edge_busy and busy=0 at cycle 107; no second burst while req stays high.
- Idle, i_encoded_SB_msg=2 with valid at cycle 5 → serial bits 6–69 give opcode 10010 on bits 0–4, msgcode 0x95 on bits 14–21, subcode 0x01 on bits 32–39; bit 63 = 1 with SB_TX_PARITY_EN, 0 without.
- During a pattern burst, strobe code 1 then code 3 → code 1 is pending, code 3 raises o_msg_drop; after done and one idle cycle, the 0x91 packet is sent; busy falls twice, giving two falling-edge pulses.
- Same-cycle start edge and valid code 3 in IDLE → pattern sent first, 0x9A packet follows after one idle cycle.
- Valid code 7 → o_unknown_msg pulses one cycle, busy stays 0, o_sb_data stays 0.
- Assert i_rst at pattern UI 20 → all outputs 0 immediately, no done pulse; after release with req still high, no new burst until req falls and rises again.
